// File: rtl/insn_decode_stage.sv
// rtl/insn_decode_stage.sv - registered instruction-decode stage with register scoreboard
// Optional macro DECODE_BYPASS_EN: same-cycle writeback masks scoreboard hazards.
module insn_decode_stage #(
  parameter int LEN_INSN      = 32,
  parameter int LEN_OPECODE   = 7,
  parameter int LEN_IMMF      = 1,
  parameter int LEN_REGNO     = 4,
  parameter int LEN_CC        = 4,
  parameter int LEN_IMM       = 16,
  parameter int LEN_IMM_EX    = 32,
  parameter int SHIFT_OPECODE = 25,
  parameter int SHIFT_IMMF    = 24,
  parameter int SHIFT_RD      = 20,
  parameter int SHIFT_RS      = 16,
  parameter int SHIFT_CC      = 0,
  parameter int SHIFT_IMM     = 0,
  localparam int NUM_REGS     = 2**LEN_REGNO
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LEN_INSN-1:0]    insn,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   flush,
  input  logic                   wb_valid,
  input  logic [LEN_REGNO-1:0]   wb_r,
  output logic [LEN_OPECODE-1:0] opecode_o,
  output logic [LEN_IMMF-1:0]    immf_o,
  output logic [LEN_REGNO-1:0]   rd_o,
  output logic [LEN_REGNO-1:0]   rs_o,
  output logic [LEN_CC-1:0]      cc_o,
  output logic [LEN_IMM_EX-1:0]  imm_o,
  output logic [NUM_REGS-1:0]    busy_o
);

  logic [LEN_OPECODE-1:0] opecode;
  logic [LEN_IMMF-1:0]    immf;
  logic [LEN_REGNO-1:0]   rd;
  logic [LEN_REGNO-1:0]   rs;
  logic [LEN_CC-1:0]      cc;
  logic [LEN_IMM-1:0]     imm;
  logic [LEN_IMM_EX-1:0]  imm_ex;
  logic                   writes_rd;
  logic                   reads_rs;
  logic                   held_writes_rd;
  logic                   hazard;
  logic                   accept;
  logic [NUM_REGS-1:0]    busy_eff;
  logic [NUM_REGS-1:0]    busy_next;
  logic                   out_valid_next;

  assign opecode = insn[SHIFT_OPECODE +: LEN_OPECODE];
  assign immf    = insn[SHIFT_IMMF +: LEN_IMMF];
  assign rd      = insn[SHIFT_RD +: LEN_REGNO];
  assign rs      = insn[SHIFT_RS +: LEN_REGNO];
  assign cc      = insn[SHIFT_CC +: LEN_CC];
  assign imm     = insn[SHIFT_IMM +: LEN_IMM];

  assign writes_rd      = (opecode[LEN_OPECODE-1 -: 3] != 3'b111);
  assign held_writes_rd = (opecode_o[LEN_OPECODE-1 -: 3] != 3'b111);
  assign reads_rs       = (immf == '0);

  always_comb begin
    imm_ex = '0;
    if (immf != '0) begin
      case (opecode[LEN_OPECODE-1 -: 4])
        4'b0000: imm_ex = LEN_IMM_EX'($signed(imm));
        4'b0001: imm_ex = LEN_IMM_EX'(imm[4:0]);
        4'b0011: imm_ex = LEN_IMM_EX'($signed(imm));
        default: imm_ex = LEN_IMM_EX'(imm);
      endcase
    end
  end

  always_comb begin
    busy_eff = busy_o;
`ifdef DECODE_BYPASS_EN
    // A register being written back this cycle is already safe to read.
    if (wb_valid) busy_eff[wb_r] = 1'b0;
`endif
  end

  assign hazard   = busy_eff[rd] | (reads_rs & busy_eff[rs]);
  assign in_ready = !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Clears are applied before the set so an accept reclaiming a register wins.
  always_comb begin
    busy_next = busy_o;
    if (wb_valid) busy_next[wb_r] = 1'b0;
    if (flush && out_valid && held_writes_rd) busy_next[rd_o] = 1'b0;
    if (accept && writes_rd) busy_next[rd] = 1'b1;
  end

  always_comb begin
    out_valid_next = out_valid;
    if (flush)          out_valid_next = 1'b0;
    else if (accept)    out_valid_next = 1'b1;
    else if (out_ready) out_valid_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      opecode_o <= '0;
      immf_o    <= '0;
      rd_o      <= '0;
      rs_o      <= '0;
      cc_o      <= '0;
      imm_o     <= '0;
      busy_o    <= '0;
    end else begin
      out_valid <= out_valid_next;
      busy_o    <= busy_next;
      if (accept) begin
        opecode_o <= opecode;
        immf_o    <= immf;
        rd_o      <= rd;
        rs_o      <= rs;
        cc_o      <= cc;
        imm_o     <= imm_ex;
      end
    end
  end

endmodule

// File: tb/tb_insn_decode_stage.sv
// tb/tb_insn_decode_stage.sv - directed self-checking bench for insn_decode_stage
module tb_insn_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] insn;
    logic        out_valid;
    logic        out_ready;
    logic        flush;
    logic        wb_valid;
    logic [3:0]  wb_r;
    logic [6:0]  opecode_o;
    logic [0:0]  immf_o;
    logic [3:0]  rd_o;
    logic [3:0]  rs_o;
    logic [3:0]  cc_o;
    logic [31:0] imm_o;
    logic [15:0] busy_o;

    int n_assert = 0;
    int n_fail   = 0;

    insn_decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .insn(insn),
        .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
        .wb_valid(wb_valid), .wb_r(wb_r), .opecode_o(opecode_o), .immf_o(immf_o),
        .rd_o(rd_o), .rs_o(rs_o), .cc_o(cc_o), .imm_o(imm_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic immf,
                                       input logic [3:0] rd, input logic [3:0] rs,
                                       input logic [15:0] imm);
        return {opc, immf, rd, rs, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; insn = '0; out_ready = 1'b0;
        flush = 1'b0; wb_valid = 1'b0; wb_r = '0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy_o, 16'h0000);
        chk("rst_imm", imm_o, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        insn = mk(7'b000_0001, 1'b1, 4'd3, 4'd0, 16'hFFF0);
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("a_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("a_out_valid", out_valid, 1'b1);
        chk("a_imm", imm_o, 32'hFFFF_FFF0);
        chk("a_opecode", opecode_o, 7'h01);
        chk("a_rd", rd_o, 4'd3);
        chk("a_busy", busy_o, 16'h0008);

        insn = mk(7'b010_0000, 1'b0, 4'd5, 4'd3, 16'h1234);
        in_valid = 1'b1;
        #1;
        chk("b_stall", in_ready, 1'b0);
        tick();
        chk("b_issue_a", out_valid, 1'b0);
        chk("b_stall2", in_ready, 1'b0);
        wb_valid = 1'b1; wb_r = 4'd3;
        #1;
`ifdef DECODE_BYPASS_EN
        chk("b_bypass_ready", in_ready, 1'b1);
        tick();
        wb_valid = 1'b0;
`else
        chk("b_wb_ready", in_ready, 1'b0);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("b_wb_busy", busy_o, 16'h0000);
        chk("b_wb_out_valid", out_valid, 1'b0);
        chk("b_ready_after_wb", in_ready, 1'b1);
        tick();
`endif
        in_valid = 1'b0;
        chk("b_out_valid", out_valid, 1'b1);
        chk("b_rd", rd_o, 4'd5);
        chk("b_rs", rs_o, 4'd3);
        chk("b_imm_immf0", imm_o, 32'h0);
        chk("b_busy", busy_o, 16'h0020);

        out_ready = 1'b0;
        insn = mk(7'b001_1000, 1'b1, 4'd7, 4'd0, 16'h8001);
        in_valid = 1'b1;
        #1;
        chk("c_bp_ready", in_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("c_hold_valid", out_valid, 1'b1);
            chk("c_hold_rd", rd_o, 4'd5);
            chk("c_hold_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        chk("c_ready", in_ready, 1'b1);
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        chk("c_out_valid", out_valid, 1'b1);
        chk("c_rd", rd_o, 4'd7);
        chk("c_imm", imm_o, 32'hFFFF_8001);
        chk("c_busy", busy_o, 16'h00A0);

        flush = 1'b1;
        insn = mk(7'b010_0000, 1'b1, 4'd9, 4'd0, 16'h0000);
        in_valid = 1'b1;
        #1;
        chk("d_flush_ready", in_ready, 1'b0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("d_flush_valid", out_valid, 1'b0);
        chk("d_flush_busy", busy_o, 16'h0020);
        wb_valid = 1'b1; wb_r = 4'd5;
        tick();
        wb_valid = 1'b0;
        chk("d_wb5_busy", busy_o, 16'h0000);

        out_ready = 1'b1;
        insn = mk(7'b000_1010, 1'b1, 4'd4, 4'd0, 16'h00FF);
        in_valid = 1'b1;
        tick();
        chk("e_imm", imm_o, 32'h0000_001F);
        chk("e_busy", busy_o, 16'h0010);
        insn = mk(7'b111_0000, 1'b1, 4'd2, 4'd0, 16'h0005);
        #1;
        chk("f_ready", in_ready, 1'b1);
        tick();
        chk("f_rd", rd_o, 4'd2);
        chk("f_cc", cc_o, 4'd5);
        chk("f_imm", imm_o, 32'h0000_0005);
        chk("f_busy", busy_o, 16'h0010);

        wb_valid = 1'b1; wb_r = 4'd4;
        insn = mk(7'b010_0001, 1'b1, 4'd8, 4'd0, 16'h0000);
        tick();
        wb_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("g_rd", rd_o, 4'd8);
        chk("g_busy", busy_o, 16'h0100);

        rst = 1'b0;
        #1;
        chk("r_out_valid", out_valid, 1'b0);
        chk("r_busy", busy_o, 16'h0000);
        chk("r_rd", rd_o, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/insn_decode_stage.md
Name: insn_decode_stage

Overview:
Registered, handshaked instruction-decode pipeline stage. Generalises the combinational field decoder with these additions:
- parametrised field widths and positions;
- a NUM_REGS-entry register scoreboard that stalls on RAW/WAW hazards;
- writeback-driven busy release;
- a flush.
Sits between fetch and execute. Drives execute with decoded opecode/immf/rd/rs/cc/extended imm plus valid.

Parameters:
LEN_INSN, 32, instruction width
LEN_OPECODE, 7, opecode width
LEN_IMMF, 1, immediate-flag width
LEN_REGNO, 4, register-number width; NUM_REGS = 2**LEN_REGNO
LEN_CC, 4, condition-code width
LEN_IMM, 16, raw immediate width
LEN_IMM_EX, 32, extended immediate width (>= LEN_IMM)
SHIFT_OPECODE, 25, opecode LSB position
SHIFT_IMMF, 24, immf LSB position
SHIFT_RD, 20, rd LSB position
SHIFT_RS, 16, rs LSB position
SHIFT_CC, 0, cc LSB position (may overlap imm)
SHIFT_IMM, 0, imm LSB position

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (asserted when 0)
in_valid  input  1  fetch presents insn
in_ready  output  1  stage accepts insn this cycle
insn  input  LEN_INSN  instruction word
out_valid  output  1  decoded instruction held
out_ready  input  1  execute takes it (issue)
flush  input  1  discard held instruction, block accept
wb_valid  input  1  writeback completes
wb_r  input  LEN_REGNO  register written back
opecode_o  output  LEN_OPECODE  registered opecode
immf_o  output  LEN_IMMF  registered immf
rd_o  output  LEN_REGNO  registered rd
rs_o  output  LEN_REGNO  registered rs
cc_o  output  LEN_CC  registered cc
imm_o  output  LEN_IMM_EX  registered extended imm
busy_o  output  NUM_REGS  scoreboard bits

Behaviour:
- Reset (rst=0, async): out_valid=0, all field outputs 0, busy_o=0. Release is synchronous to clk.
- Field extraction: fld = insn[LEN+SHIFT-1:SHIFT] for each field.
- writes_rd = (opecode[6:4] != 3'b111). reads_rs = (immf == 0). rd is always read.
- hazard = busy[rd] | (reads_rs & busy[rs]), evaluated combinationally on incoming insn.
- in_ready = !flush & !hazard & (!out_valid | out_ready). Combinational; no dependency on in_valid.
- Accept (in_valid & in_ready): next edge loads all outputs, out_valid=1. If writes_rd, busy[rd] is set. Latency is 1 cycle; back-to-back accepts give full throughput when there is no hazard.
- Issue (out_valid & out_ready & !flush) without accept: out_valid becomes 0. Outputs hold their last values.
- Flush: next edge out_valid=0. If the held instruction writes_rd, its busy[rd_o] is cleared. Flush overrides out_ready.
- wb_valid: busy[wb_r] cleared next edge. Writeback to a non-busy register is a no-op.
- Simultaneous set and clear of the same register: set wins. Simultaneous flush-clear and wb-clear: both clear.
- imm decode:
  - immf=0 -> 0.
  - opecode 000_0xxx -> sign-extend imm.
  - opecode 000_1xxx -> zero-extend imm[4:0].
  - opecode 001_1xxx -> sign-extend imm.
  - else -> zero-extend imm.
- Register r0 is not special; it is tracked like any other register.

Optional Feature:
DECODE_BYPASS_EN:
- Defined: in the hazard equation, busy[x] is masked when wb_valid & wb_r==x in the same cycle. This allows accept in the writeback cycle. If the accepted insn writes that same rd, busy stays set (set wins).
- Undefined: hazard uses registered busy only, giving one extra stall cycle after writeback.

Test Plan:
1. Reset with rst=0 mid-stream -> out_valid=0, busy_o=0 immediately, before any clk edge.
2. Accept insn opecode=000_0001, immf=1, rd=3, imm=16'hFFF0 -> next cycle out_valid=1, imm_o=32'hFFFF_FFF0, busy_o[3]=1.
3. Hold busy[3]=1; present an insn with rd=5, immf=0, rs=3 -> in_ready=0. wb_valid with wb_r=3 -> busy clears; accept one cycle later without bypass, same cycle with DECODE_BYPASS_EN.
4. out_ready=0 with out_valid=1 -> in_ready=0 and outputs stable for 4 cycles. Raise out_ready -> issue and accept next insn in the same cycle.
5. Held insn rd=7 (writes_rd) with flush=1 -> out_valid=0 and busy_o[7]=0 next cycle; in_ready=0 during the flush cycle.
6. Opecode 000_1010, imm=16'h00FF -> imm_o=32'h0000_001F. Opecode 111_0000, rd=2 -> busy_o[2] stays 0.
